pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It sequences multi-cycle MUL/DIV execution and data-cache refills, and resolves load-use and taken-branch hazards. It drives StallF, Mstall and Cache_Stall into the program counter, plus the stall/flush controls for the D/E/M pipeline registers. It also keeps a stall-cycle performance counter and a multi-cycle watchdog flag.

## Interface
- MC_TIMEOUT, 64: cycles in MC_WAIT before McTimeout sets
- CNT_W, 32: width of StallCycles
- CLK  in  1  clock
- Reset  in  1  asynchronous, active-high
- StartMCycleE  in  1  multi-cycle op present in E
- MCycleDone  in  1  multi-cycle unit result valid (1-cycle pulse)
- CacheMissM  in  1  data-cache miss for instruction in M
- CacheRefillDone  in  1  refill complete (1-cycle pulse)
- LoadUseD  in  1  load-use hazard detected in D
- PCSrcE  in  1  taken branch/jump resolved in E
- StallF  out  1  PC hold for hazards (PC separately ORs Mstall, Cache_Stall)
- Mstall  out  1  multi-cycle stall to PC
- Cache_Stall  out  1  cache stall to PC
- StallD, StallE, StallM  out  1  pipeline register holds
- FlushD, FlushE, FlushM  out  1  pipeline register bubbles
- MCycleStart  out  1  start pulse to multi-cycle unit
- McTimeout  out  1  sticky watchdog flag
- StallCycles  out  CNT_W  stall-cycle count

## Operation
- States: RUN, MC_WAIT, CACHE_WAIT. Outputs are Mealy, combinational from state and inputs.
- RUN, priority high→low:
  - CacheMissM: Cache_Stall=StallD=StallE=StallM=1; next CACHE_WAIT.
  - StartMCycleE: MCycleStart=1, Mstall=StallD=StallE=1, FlushM=1; next MC_WAIT.
  - PCSrcE: FlushD=FlushE=1; StallF=0.
  - LoadUseD without PCSrcE: StallF=StallD=1, FlushE=1.
  - PCSrcE with LoadUseD: the branch wins. StallF=0 so the redirect is not lost.
- MC_WAIT:
  - While MCycleDone=0: Mstall=StallD=StallE=1, FlushM=1.
  - In the MCycleDone cycle: all stalls 0; next RUN.
  - CacheMissM, LoadUseD and PCSrcE are ignored, because M holds bubbles.
- CACHE_WAIT:
  - While CacheRefillDone=0: Cache_Stall=StallD=StallE=StallM=1.
  - In the CacheRefillDone cycle with StartMCycleE=1: Cache_Stall=0, MCycleStart=1, Mstall=StallD=StallE=1, FlushM=1; next MC_WAIT.
  - In the CacheRefillDone cycle otherwise: all stalls 0; next RUN.
- Watchdog:
  - A counter clears on entry to MC_WAIT and increments each MC_WAIT cycle.
  - When it reaches MC_TIMEOUT, McTimeout sets. McTimeout is sticky until Reset; the FSM keeps waiting.
- StallCycles:
  - +1 on each rising edge where StallF|Mstall|Cache_Stall=1.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset values: state RUN, StallCycles 0, McTimeout 0, watchdog 0. All outputs are 0 while inputs are 0.
- Stalls assert in the same cycle as the triggering input; there is zero-cycle latency to the PC.
- MCycleStart is exactly one cycle wide per multi-cycle op. It is never reasserted while in MC_WAIT.
- Done in the entry cycle is not possible: MCycleDone is sampled only from the cycle after MCycleStart.
- Total Mstall cycles per op = (cycle of MCycleDone − cycle of MCycleStart).
- Reset asserted mid-MC_WAIT or mid-CACHE_WAIT returns the FSM to RUN immediately. Mstall and Cache_Stall drop asynchronously.
- Simultaneous CacheMissM and StartMCycleE in RUN: cache first, then multi-cycle via the CACHE_WAIT→MC_WAIT path.

## Structure
- Shared package: state encoding (RUN=2'b00, MC_WAIT=2'b01, CACHE_WAIT=2'b10) and the default MC_TIMEOUT constant.
- One sub-module, stall_perf_counter: CNT_W-bit wrapping counter with enable and async reset, used for StallCycles.
- FSM, watchdog and output decode stay in the top module.

## Test plan
- Reset, all inputs 0 → all outputs 0, StallCycles=0.
- StartMCycleE at cycle 2, MCycleDone at cycle 7 → MCycleStart high in cycle 2 only; Mstall high cycles 2–6, low in 7; StallCycles=5.
- CacheMissM and StartMCycleE together at cycle 2, CacheRefillDone at cycle 5 → Cache_Stall high 2–4; MCycleStart in 5; Mstall from 5 until done.
- LoadUseD with PCSrcE same cycle → StallF=0, FlushD=FlushE=1, StallD=0. LoadUseD alone → StallF=StallD=FlushE=1 for one cycle.
- MC_TIMEOUT=4, MCycleDone withheld 10 cycles → McTimeout rises after 4 MC_WAIT cycles and stays high after done; cleared only by Reset.
- Reset pulsed in the 3rd MC_WAIT cycle → Mstall=0 immediately, state RUN, StallCycles=0, a later MCycleDone ignored.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding
// and the default multi-cycle watchdog limit.
package pipeline_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    MC_WAIT    = 2'b01,
    CACHE_WAIT = 2'b10
  } state_e;

  localparam int unsigned MC_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/pipeline_stall_ctrl_perf_counter.sv
// Free-running wrapping event counter used to accumulate stall cycles.
module stall_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             En,
  output logic [CNT_W-1:0] Count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (En) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign Count = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: multi-cycle op and cache-refill waits, load-use
// and taken-branch hazards, stall-cycle counter and multi-cycle watchdog.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MC_TIMEOUT = MC_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             StartMCycleE,
  input  logic             MCycleDone,
  input  logic             CacheMissM,
  input  logic             CacheRefillDone,
  input  logic             LoadUseD,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             Mstall,
  output logic             Cache_Stall,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MCycleStart,
  output logic             McTimeout,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int unsigned WD_W = $clog2(MC_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              mc_timeout_q, mc_timeout_d;

  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    mc_timeout_d = mc_timeout_q;
    StallF       = 1'b0;
    Mstall       = 1'b0;
    Cache_Stall  = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    FlushM       = 1'b0;
    MCycleStart  = 1'b0;

    case (state_q)
      RUN: begin
        if (CacheMissM) begin
          Cache_Stall = 1'b1;
          StallD      = 1'b1;
          StallE      = 1'b1;
          StallM      = 1'b1;
          state_d     = CACHE_WAIT;
        end else if (StartMCycleE) begin
          MCycleStart = 1'b1;
          Mstall      = 1'b1;
          StallD      = 1'b1;
          StallE      = 1'b1;
          FlushM      = 1'b1;
          wd_d        = '0;
          state_d     = MC_WAIT;
        end else if (PCSrcE) begin
          // Branch beats load-use: StallF stays low so the redirect is taken.
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (LoadUseD) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end

      MC_WAIT: begin
        if (!MCycleDone) begin
          Mstall = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          FlushM = 1'b1;
        end else begin
          state_d = RUN;
        end
        if (wd_q != WD_W'(MC_TIMEOUT)) wd_d = wd_q + WD_W'(1);
        if (wd_q == WD_W'(MC_TIMEOUT - 1)) mc_timeout_d = 1'b1;
      end

      CACHE_WAIT: begin
        if (!CacheRefillDone) begin
          Cache_Stall = 1'b1;
          StallD      = 1'b1;
          StallE      = 1'b1;
          StallM      = 1'b1;
        end else if (StartMCycleE) begin
          MCycleStart = 1'b1;
          Mstall      = 1'b1;
          StallD      = 1'b1;
          StallE      = 1'b1;
          FlushM      = 1'b1;
          wd_d        = '0;
          state_d     = MC_WAIT;
        end else begin
          state_d = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q      <= RUN;
      wd_q         <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign McTimeout = mc_timeout_q;

  stall_perf_counter #(
    .CNT_W(CNT_W)
  ) u_perf (
    .CLK  (CLK),
    .Reset(Reset),
    .En   (StallF | Mstall | Cache_Stall),
    .Count(StallCycles)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: hand-computed output vectors per cycle.
module tb_pipeline_stall_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        StartMCycleE, MCycleDone, CacheMissM, CacheRefillDone, LoadUseD, PCSrcE;
  logic        StallF, Mstall, Cache_Stall, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushM, MCycleStart, McTimeout;
  logic [31:0] StallCycles;
  logic [9:0]  outs2;
  logic        McTimeout2;
  logic [2:0]  StallCycles2;
  logic [9:0]  outs;

  int checks = 0;
  int errors = 0;

  // Output vector order: StallF Mstall Cache_Stall StallD StallE StallM FlushD FlushE FlushM MCycleStart
  localparam logic [9:0] O_NONE    = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] O_MCSTART = 10'b0_1_0_1_1_0_0_0_1_1;
  localparam logic [9:0] O_MCWAIT  = 10'b0_1_0_1_1_0_0_0_1_0;
  localparam logic [9:0] O_CACHE   = 10'b0_0_1_1_1_1_0_0_0_0;
  localparam logic [9:0] O_BRANCH  = 10'b0_0_0_0_0_0_1_1_0_0;
  localparam logic [9:0] O_LOADUSE = 10'b1_0_0_1_0_0_0_1_0_0;

  always #5 CLK = ~CLK;

  assign outs = {StallF, Mstall, Cache_Stall, StallD, StallE, StallM, FlushD, FlushE, FlushM, MCycleStart};

  pipeline_stall_ctrl #(.MC_TIMEOUT(4), .CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset),
    .StartMCycleE(StartMCycleE), .MCycleDone(MCycleDone), .CacheMissM(CacheMissM),
    .CacheRefillDone(CacheRefillDone), .LoadUseD(LoadUseD), .PCSrcE(PCSrcE),
    .StallF(StallF), .Mstall(Mstall), .Cache_Stall(Cache_Stall),
    .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MCycleStart(MCycleStart), .McTimeout(McTimeout), .StallCycles(StallCycles)
  );

  // Narrow-counter instance to exercise wraparound.
  pipeline_stall_ctrl #(.MC_TIMEOUT(4), .CNT_W(3)) dut_w3 (
    .CLK(CLK), .Reset(Reset),
    .StartMCycleE(StartMCycleE), .MCycleDone(MCycleDone), .CacheMissM(CacheMissM),
    .CacheRefillDone(CacheRefillDone), .LoadUseD(LoadUseD), .PCSrcE(PCSrcE),
    .StallF(outs2[9]), .Mstall(outs2[8]), .Cache_Stall(outs2[7]),
    .StallD(outs2[6]), .StallE(outs2[5]), .StallM(outs2[4]),
    .FlushD(outs2[3]), .FlushE(outs2[2]), .FlushM(outs2[1]),
    .MCycleStart(outs2[0]), .McTimeout(McTimeout2), .StallCycles(StallCycles2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic st, input logic dn, input logic ms,
                        input logic rd, input logic lu, input logic pc);
    StartMCycleE    = st;
    MCycleDone      = dn;
    CacheMissM      = ms;
    CacheRefillDone = rd;
    LoadUseD        = lu;
    PCSrcE          = pc;
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    chk("reset_outs", 32'(outs), 32'(O_NONE));
    chk("reset_cnt", StallCycles, 0);
    chk("reset_timeout", 32'(McTimeout), 0);
    tick; tick;
    Reset = 1'b0;
    tick;
    chk("idle_outs", 32'(outs), 32'(O_NONE));

    // Multi-cycle op: start in cycle 2, done in cycle 7; op stays in E throughout.
    set_in(1, 0, 0, 0, 0, 0);
    chk("mc_start", 32'(outs), 32'(O_MCSTART));
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("mc_wait", 32'(outs), 32'(O_MCWAIT));
      if (i == 3) chk("mc_timeout_pre", 32'(McTimeout), 0);
      tick;
    end
    set_in(1, 1, 0, 0, 0, 0);
    chk("mc_done", 32'(outs), 32'(O_NONE));
    chk("mc_timeout_set", 32'(McTimeout), 1);
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    chk("mc_cnt", StallCycles, 5);
    chk("mc_cnt_w3", 32'(StallCycles2), 5);
    chk("mc_timeout_sticky", 32'(McTimeout), 1);
    chk("mc_after_outs", 32'(outs), 32'(O_NONE));

    Reset = 1'b1;
    #1;
    chk("rst_timeout_clr", 32'(McTimeout), 0);
    chk("rst_cnt_clr", StallCycles, 0);
    tick;
    Reset = 1'b0;
    tick;

    // Cache miss together with multi-cycle start: cache first, then MC via refill.
    set_in(1, 0, 1, 0, 0, 0);
    chk("cm_first", 32'(outs), 32'(O_CACHE));
    tick;
    chk("cm_wait1", 32'(outs), 32'(O_CACHE));
    tick;
    chk("cm_wait2", 32'(outs), 32'(O_CACHE));
    tick;
    set_in(1, 0, 1, 1, 0, 0);
    chk("cm_refill_mcstart", 32'(outs), 32'(O_MCSTART));
    tick;
    set_in(1, 0, 1, 0, 1, 1);
    chk("cm_mcwait_ignores", 32'(outs), 32'(O_MCWAIT));
    tick;
    set_in(0, 1, 0, 0, 0, 0);
    chk("cm_mcdone", 32'(outs), 32'(O_NONE));
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    chk("cm_cnt", StallCycles, 5);
    chk("cm_timeout", 32'(McTimeout), 0);

    // Hazards.
    set_in(0, 0, 0, 0, 1, 1);
    chk("br_beats_lu", 32'(outs), 32'(O_BRANCH));
    tick;
    set_in(0, 0, 0, 0, 1, 0);
    chk("loaduse", 32'(outs), 32'(O_LOADUSE));
    tick;
    set_in(0, 0, 0, 0, 0, 1);
    chk("branch_only", 32'(outs), 32'(O_BRANCH));
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    chk("hz_cnt", StallCycles, 6);

    // Cache miss outranks branch and load-use.
    set_in(0, 0, 1, 0, 1, 1);
    chk("cm_priority", 32'(outs), 32'(O_CACHE));
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    chk("cw_hold", 32'(outs), 32'(O_CACHE));
    tick;
    set_in(0, 0, 0, 1, 0, 0);
    chk("cw_done", 32'(outs), 32'(O_NONE));
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    chk("cw_back_run", 32'(outs), 32'(O_NONE));
    chk("cw_cnt", StallCycles, 8);
    chk("cw_cnt_w3_wrap", 32'(StallCycles2), 0);

    // Reset in the third MC_WAIT cycle.
    set_in(1, 0, 0, 0, 0, 0);
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    tick; tick;
    chk("rm_wait3", 32'(outs), 32'(O_MCWAIT));
    Reset = 1'b1;
    #1;
    chk("rm_outs_drop", 32'(outs), 32'(O_NONE));
    chk("rm_cnt", StallCycles, 0);
    tick;
    Reset = 1'b0;
    set_in(0, 1, 0, 0, 0, 0);
    chk("rm_done_ignored", 32'(outs), 32'(O_NONE));
    tick;
    set_in(0, 0, 0, 0, 0, 0);
    chk("rm_cnt_after", StallCycles, 0);
    set_in(1, 0, 0, 0, 0, 0);
    chk("rm_run_state", 32'(outs), 32'(O_MCSTART));
    tick;
    set_in(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
